mem_stage_responder: RTL and testbench
======================================

Name: mem_stage_responder

Overview:
- Data-memory responder serving the MEM-stage load/store requests issued by the ARM pipeline.
- Models an off-chip SRAM with a fixed number of wait states.
- Drives a ready handshake; the datapath uses the inverse of ready as the freeze for all pipeline registers.
- Holds the word-addressed storage array internally and returns load data on completion.

Parameters:
- BASE_ADDR, 32'd1024: byte address that maps to word 0.
- DEPTH, 64: number of 32-bit words stored.
- WAIT_CYCLES, 5: BUSY cycles per access, legal range 1..15.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- mem_r_en, input, 1: load request, held by the pipeline until ready.
- mem_w_en, input, 1: store request, held by the pipeline until ready.
- address, input, 32: byte address from the ALU result.
- write_data, input, 32: store data (the Rm value).
- read_data, output, 32: load result, valid while ready=1 in DONE.
- ready, output, 1: 0 means freeze the pipeline; 1 means the request has completed or there is no request.
- addr_err, output, 1: one-cycle pulse in DONE when the address is out of range, or when both requests were asserted together.

Behaviour:
- Reset (asynchronous): state=IDLE, count=0, read_data=0, addr_err=0, latched address/data=0. The storage array is not cleared.
- Address decode:
  - idx = (address - BASE_ADDR) >> 2; address[1:0] are ignored.
  - in_range = (address >= BASE_ADDR) && (idx < DEPTH).
  - All subtraction is 32-bit unsigned; an address below BASE_ADDR wraps and is out of range.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - ready = ~(mem_r_en | mem_w_en), combinational. Ready drops in the same cycle a request appears.
  - On a request, latch address, write_data and the op, set count=0, go to BUSY.
- BUSY:
  - ready=0; count increments each cycle.
  - When count == WAIT_CYCLES-1, go to DONE.
  - Inputs are not sampled after latching; a flush or a dropped request mid-BUSY does not abort the access.
- Transition BUSY->DONE:
  - Write: if in_range, mem[idx] <= latched data; otherwise no write.
  - Read: read_data <= mem[idx] if in_range, else 32'd0.
  - addr_err <= ~in_range, or 1 if both mem_r_en and mem_w_en were set at latch.
- DONE:
  - ready=1 for exactly one cycle; the pipeline advances on this edge.
  - Go to IDLE unconditionally. A request still high in DONE is the consumed one and is ignored.
  - addr_err clears on leaving DONE.
- Read and write together is illegal: treated as a write, with addr_err flagged.
- Latency:
  - Request seen in cycle 0 gives ready=1 in cycle WAIT_CYCLES+1.
  - Stall length is WAIT_CYCLES+1 cycles.
  - Back-to-back accesses restart from IDLE; ready=1 is never held for more than one cycle while a request is pending.
- read_data holds its value outside DONE; it updates only on a read completion.
- Reset mid-BUSY:
  - The access is aborted and no write occurs.
  - ready follows the IDLE rule immediately after reset.

Optional Feature:
- Macro: MEM_STATS_EN.
- When defined:
  - Adds output ports rd_count[15:0] and wr_count[15:0].
  - Each counter increments on the BUSY->DONE transition of its op type, whether the address is in range or not.
  - Both counters saturate at 16'hFFFF and reset to 0 on rst.
  - An illegal read+write access counts as a write only.
- When undefined:
  - Neither port exists.
  - No counter logic is present.
  - All other behaviour is identical.

Test Plan:
- Idle, no request -> ready=1 continuously; read_data=0 after reset.
- Store: mem_w_en=1, address=1024+8, write_data=32'hDEADBEEF, WAIT_CYCLES=5 -> ready=0 for cycles 0..5, ready=1 in cycle 6. Then load from the same address -> read_data=32'hDEADBEEF with ready=1 exactly 6 cycles after the request.
- Back-to-back: store to 1028, then load from 1028 held continuously -> two separate 6-cycle stalls; ready=1 for a single cycle between them; load returns the stored value.
- Out of range:
  - Load from address=1020 -> read_data=0, addr_err pulses in DONE.
  - Store to 1024+4*DEPTH -> no array word changes, addr_err pulses.
- Async reset asserted mid-BUSY of a store 32'h12345678 to 1032 -> state IDLE immediately; a later load from 1032 returns the prior value (0 if never written); no spurious ready pulse from DONE.
- With MEM_STATS_EN: 3 loads, 2 stores, and 1 read+write -> rd_count=3, wr_count=3, addr_err pulsed once.

Source files
------------

// File: rtl/mem_stage_responder.sv
// MEM-stage data memory responder: fixed wait-state SRAM model with a ready/freeze handshake.
// Optional MEM_STATS_EN adds saturating load/store completion counters.
module mem_stage_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        addr_err
`ifdef MEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  count;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic        lat_wr;
  logic        lat_both;

  logic [31:0] offset;
  logic [31:0] idx;
  logic [AW-1:0] mem_idx;
  logic        in_range;
  logic        request;
  logic        last_busy;

  logic [31:0] mem [DEPTH];

  // Decode always works on the latched address; a low address wraps and fails the >= test.
  assign offset    = lat_addr - BASE_ADDR;
  assign idx       = offset >> 2;
  assign mem_idx   = idx[AW-1:0];
  assign in_range  = (lat_addr >= BASE_ADDR) && (idx < 32'(DEPTH));
  assign request   = mem_r_en | mem_w_en;
  assign last_busy = (state == BUSY) && (count == 4'(WAIT_CYCLES - 1));

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = ~request;
        if (request) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_busy) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 4'd0;
      lat_addr  <= 32'd0;
      lat_data  <= 32'd0;
      lat_wr    <= 1'b0;
      lat_both  <= 1'b0;
      read_data <= 32'd0;
      addr_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && request) begin
        count    <= 4'd0;
        lat_addr <= address;
        lat_data <= write_data;
        lat_wr   <= mem_w_en;
        lat_both <= mem_r_en & mem_w_en;
      end else if (state == BUSY) begin
        count <= count + 4'd1;
      end

      if (last_busy) begin
        if (!lat_wr) read_data <= in_range ? mem[mem_idx] : 32'd0;
        addr_err <= ~in_range | lat_both;
      end else if (state == DONE) begin
        addr_err <= 1'b0;
      end
    end
  end

  // NOTE: the storage array has no reset; it models SRAM contents that survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (last_busy && lat_wr && in_range) mem[mem_idx] <= lat_data;
  end

`ifdef MEM_STATS_EN
  // A read+write access was latched with lat_wr set, so it lands in the write counter only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (last_busy) begin
      if (lat_wr) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_responder.sv
// Directed self-checking bench for mem_stage_responder (default parameters).
// Define MEM_STATS_EN on both RTL and bench to exercise the counter ports.
module tb_mem_stage_responder;

  logic        clk;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        addr_err;
`ifdef MEM_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  int tests_run;
  int tests_failed;

  mem_stage_responder dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .addr_err   (addr_err)
`ifdef MEM_STATS_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives a request (left asserted on return) and waits for ready; returns the
  // cycle index of ready (request cycle = 0), the load data and addr_err seen then.
  task automatic access(input logic r, input logic w, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] rd,
                        output logic err, output int lat, output int early_err);
    mem_r_en   = r;
    mem_w_en   = w;
    address    = addr;
    write_data = data;
    lat        = -1;
    rd         = 32'hx;
    err        = 1'bx;
    early_err  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready) begin
        lat = c;
        rd  = read_data;
        err = addr_err;
        break;
      end
      if (addr_err) early_err++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drop();
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          early;
  int          err_sum;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b1;
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;

    // Reset state and idle behaviour
    @(posedge clk);
    #1;
    check("rst_read_data", read_data, 32'd0);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, ready}, 32'd1);
    end
    @(posedge clk);
    #1;

    // Ready drops combinationally in the request cycle
    mem_w_en = 1'b1;
    address  = 32'd1024;
    #1;
    check("ready_comb_drop", {31'd0, ready}, 32'd0);
    access(1'b0, 1'b1, 32'd1024, 32'h11111111, rd, err, lat, early);
    drop();
    check("st1024_lat", lat, 32'd6);

    // Store then load at 1024+8
    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, rd, err, lat, early);
    drop();
    check("st1032_lat", lat, 32'd6);
    check("st1032_err", {31'd0, err}, 32'd0);
    check("st1032_rd_hold", rd, 32'd0);
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'd1032, 32'd0, rd, err, lat, early);
    drop();
    check("ld1032_lat", lat, 32'd6);
    check("ld1032_data", rd, 32'hDEADBEEF);

    // Back-to-back: store held, then load held with no idle gap
    access(1'b0, 1'b1, 32'd1028, 32'hA5A55A5A, rd, err, lat, early);
    check("b2b_st_lat", lat, 32'd6);
    access(1'b1, 1'b0, 32'd1028, 32'd0, rd, err, lat, early);
    check("b2b_ld_lat", lat, 32'd6);
    check("b2b_ld_data", rd, 32'hA5A55A5A);
    drop();

    // Load below base address
    access(1'b1, 1'b0, 32'd1020, 32'd0, rd, err, lat, early);
    drop();
    check("ld1020_data", rd, 32'd0);
    check("ld1020_err", {31'd0, err}, 32'd1);
    check("ld1020_no_early_err", early, 32'd0);
    @(negedge clk);
    check("err_cleared", {31'd0, addr_err}, 32'd0);
    @(posedge clk);
    #1;

    // Store one past the top must not alias onto any word
    access(1'b0, 1'b1, 32'd1276, 32'h77777777, rd, err, lat, early);
    drop();
    access(1'b0, 1'b1, 32'd1280, 32'hFFFFFFFF, rd, err, lat, early);
    drop();
    check("st_oor_err", {31'd0, err}, 32'd1);
    access(1'b1, 1'b0, 32'd1024, 32'd0, rd, err, lat, early);
    drop();
    check("word0_intact", rd, 32'h11111111);
    access(1'b1, 1'b0, 32'd1276, 32'd0, rd, err, lat, early);
    drop();
    check("word63_intact", rd, 32'h77777777);
    check("word63_err", {31'd0, err}, 32'd0);
    access(1'b1, 1'b0, 32'd1026, 32'd0, rd, err, lat, early);
    drop();
    check("byte_off_ignored", rd, 32'h11111111);

    // Read+write together: treated as a write, flagged, read_data held
    access(1'b1, 1'b1, 32'd1036, 32'h0BADC0DE, rd, err, lat, early);
    drop();
    check("rw_err", {31'd0, err}, 32'd1);
    check("rw_rd_hold", rd, 32'h11111111);
    access(1'b1, 1'b0, 32'd1036, 32'd0, rd, err, lat, early);
    drop();
    check("rw_wrote", rd, 32'h0BADC0DE);

    // Async reset mid-BUSY aborts the store
    access(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, rd, err, lat, early);
    drop();
    mem_w_en   = 1'b1;
    address    = 32'd1032;
    write_data = 32'h12345678;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy_ready_req", {31'd0, ready}, 32'd0);
    check("rst_busy_read_data", read_data, 32'd0);
    drop();
    #1;
    check("rst_busy_ready_idle", {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_idle", {31'd0, ready}, 32'd1);
    end
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'd1032, 32'd0, rd, err, lat, early);
    drop();
    check("rst_abort_lat", lat, 32'd6);
    check("rst_abort_data", rd, 32'hCAFEF00D);

`ifdef MEM_STATS_EN
    // One load already done since reset; add 2 loads, 2 stores, 1 read+write
    err_sum = 0;
    access(1'b1, 1'b0, 32'd1024, 32'd0, rd, err, lat, early);
    drop();
    err_sum += int'(err);
    access(1'b0, 1'b1, 32'd1040, 32'h1, rd, err, lat, early);
    drop();
    err_sum += int'(err);
    access(1'b1, 1'b0, 32'd1040, 32'd0, rd, err, lat, early);
    drop();
    err_sum += int'(err);
    access(1'b0, 1'b1, 32'd1044, 32'h2, rd, err, lat, early);
    drop();
    err_sum += int'(err);
    access(1'b1, 1'b1, 32'd1048, 32'h3, rd, err, lat, early);
    drop();
    err_sum += int'(err);
    check("stats_rd_count", {16'd0, rd_count}, 32'd3);
    check("stats_wr_count", {16'd0, wr_count}, 32'd3);
    check("stats_err_once", err_sum, 32'd1);
`else
    err_sum = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
